// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for the single-port data memory: CPU load/store path and debug/loader port.
// Each access is arbitrate (IDLE) then access (ACCESS); read data returns the cycle after ACCESS.
module data_mem_arbiter #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 2,
    parameter int CPU_PRIORITY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Handshake: a requester holds req with a stable command until it sees gnt (one cycle,
    // during ACCESS); reads then get a one-cycle rvalid with rdata on the following cycle.
    // A req still high after the gnt cycle is treated as a fresh request.

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic       PORT_CPU   = 1'b0;
    localparam logic       PORT_DBG   = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    state_t              state, state_next;
    logic                owner;
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic                last_winner;
    logic [3:0]          wait_cnt, wait_next;
    logic                any_req;
    logic                pick_dbg;

    always_comb begin
        any_req  = cpu_req | dbg_req;
        pick_dbg = 1'b0;
        if (dbg_req && !cpu_req) begin
            pick_dbg = 1'b1;
        end else if (dbg_req && cpu_req) begin
            if (CPU_PRIORITY != 0) pick_dbg = (wait_cnt >= STARVE_LIM);
            else                   pick_dbg = (last_winner == PORT_CPU);
        end
    end

    // Starvation counter only moves in IDLE; ACCESS cycles are not counted as waiting.
    always_comb begin
        wait_next = wait_cnt;
        if (state == IDLE) begin
            if (dbg_req && !pick_dbg) wait_next = (wait_cnt == 4'd15) ? wait_cnt : wait_cnt + 4'd1;
            else                      wait_next = 4'd0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= PORT_CPU;
            cmd_we      <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            last_winner <= PORT_DBG;
            wait_cnt    <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (state == IDLE && any_req) begin
                owner       <= pick_dbg;
                last_winner <= pick_dbg;
                cmd_we      <= pick_dbg ? dbg_we    : cpu_we;
                cmd_addr    <= pick_dbg ? dbg_addr  : cpu_addr;
                cmd_wdata   <= pick_dbg ? dbg_wdata : cpu_wdata;
            end
        end
    end

    // Read return: capture at the end of ACCESS, so a reset during ACCESS drops it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            if (state == ACCESS && !cmd_we) begin
                if (owner == PORT_DBG) begin
                    dbg_rvalid <= 1'b1;
                    dbg_rdata  <= mem_rdata;
                end else begin
                    cpu_rvalid <= 1'b1;
                    cpu_rdata  <= mem_rdata;
                end
            end
        end
    end

    assign busy      = (state == ACCESS);
    assign cpu_gnt   = busy && (owner == PORT_CPU);
    assign dbg_gnt   = busy && (owner == PORT_DBG);
    assign mem_we    = busy && cmd_we;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a CPU-priority instance (p_*) and a round-robin instance (r_*)
// share the requester inputs; each is held in reset while the other is exercised.
module tb_data_mem_arbiter;

    localparam int DW = 8;
    localparam int AW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_p, reset_r;
    logic cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;

    logic p_cpu_gnt, p_cpu_rvalid, p_dbg_gnt, p_dbg_rvalid, p_mem_we, p_busy;
    logic [DW-1:0] p_cpu_rdata, p_dbg_rdata, p_mem_wdata, p_mem_rdata;
    logic [AW-1:0] p_mem_addr;
    logic r_cpu_gnt, r_cpu_rvalid, r_dbg_gnt, r_dbg_rvalid, r_mem_we, r_busy;
    logic [DW-1:0] r_cpu_rdata, r_dbg_rdata, r_mem_wdata, r_mem_rdata;
    logic [AW-1:0] r_mem_addr;

    logic [DW-1:0] p_mem [4];
    logic [DW-1:0] r_mem [4];
    logic [DW-1:0] ref_mem [4];

    logic          gnt_q[$];
    logic          rr_q[$];
    logic [DW-1:0] cpu_rd_q[$];
    logic [DW-1:0] dbg_rd_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int rr_last = -1;

    data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CPU_PRIORITY(1), .STARVE_LIMIT(4)) u_pri (
        .clk(clk), .reset(reset_p),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(p_cpu_gnt), .cpu_rvalid(p_cpu_rvalid), .cpu_rdata(p_cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(p_dbg_gnt), .dbg_rvalid(p_dbg_rvalid), .dbg_rdata(p_dbg_rdata),
        .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
        .mem_rdata(p_mem_rdata), .busy(p_busy)
    );

    data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CPU_PRIORITY(0), .STARVE_LIMIT(4)) u_rr (
        .clk(clk), .reset(reset_r),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(r_cpu_gnt), .cpu_rvalid(r_cpu_rvalid), .cpu_rdata(r_cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(r_dbg_gnt), .dbg_rvalid(r_dbg_rvalid), .dbg_rdata(r_dbg_rdata),
        .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
        .mem_rdata(r_mem_rdata), .busy(r_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (p_mem_we) p_mem[p_mem_addr] <= p_mem_wdata;
    always @(posedge clk) if (r_mem_we) r_mem[r_mem_addr] <= r_mem_wdata;
    assign p_mem_rdata = p_mem[p_mem_addr];
    assign r_mem_rdata = r_mem[r_mem_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic got_gnt(input bit sel, input bit port);
        if (sel) return port ? r_dbg_gnt : r_cpu_gnt;
        return port ? p_dbg_gnt : p_cpu_gnt;
    endfunction

    // Drive one command (called at posedge+1), wait for its grant, then drop req at the next posedge+1.
    task automatic issue(input bit sel, input bit port, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input bit push_gnt);
        int waited;
        if (port) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        if (!sel) begin
            if (push_gnt) gnt_q.push_back(port);
            if (we)        ref_mem[addr] = wdata;
            else if (port) dbg_rd_q.push_back(ref_mem[addr]);
            else           cpu_rd_q.push_back(ref_mem[addr]);
        end
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!got_gnt(sel, port) && waited < 40);
        check_val(port ? "dbg_gnt_seen" : "cpu_gnt_seen", 32'(got_gnt(sel, port)), 32'd1);
        step();
        if (port) dbg_req = 1'b0;
        else      cpu_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset_p) begin
            if (p_cpu_gnt || p_dbg_gnt) begin
                if (gnt_q.size() == 0) check_val("p_gnt_unexpected", 32'({p_dbg_gnt, p_cpu_gnt}), 32'd0);
                else begin
                    check_val("p_gnt_id", 32'({p_dbg_gnt, p_cpu_gnt}), 32'({gnt_q[0], ~gnt_q[0]}));
                    void'(gnt_q.pop_front());
                end
            end
            if (p_cpu_rvalid) begin
                if (cpu_rd_q.size() == 0) check_val("p_cpu_rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    check_val("p_cpu_rdata", 32'(p_cpu_rdata), 32'(cpu_rd_q[0]));
                    void'(cpu_rd_q.pop_front());
                end
            end
            if (p_dbg_rvalid) begin
                if (dbg_rd_q.size() == 0) check_val("p_dbg_rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    check_val("p_dbg_rdata", 32'(p_dbg_rdata), 32'(dbg_rd_q[0]));
                    void'(dbg_rd_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_r) begin
            if (r_cpu_gnt || r_dbg_gnt) begin
                if (rr_q.size() == 0) check_val("r_gnt_unexpected", 32'({r_dbg_gnt, r_cpu_gnt}), 32'd0);
                else begin
                    check_val("r_gnt_id", 32'({r_dbg_gnt, r_cpu_gnt}), 32'({rr_q[0], ~rr_q[0]}));
                    void'(rr_q.pop_front());
                end
                if (rr_last >= 0) check_val("r_gnt_spacing", 32'(cyc - rr_last), 32'd2);
                rr_last = cyc;
            end
            if (r_cpu_rvalid || r_dbg_rvalid) check_val("r_rvalid_on_write", 32'd1, 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        reset_p = 1'b1; reset_r = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        repeat (3) step();
        reset_p = 1'b0;
        @(negedge clk);
        check_val("rst_cpu_gnt",    32'(p_cpu_gnt),    32'd0);
        check_val("rst_dbg_gnt",    32'(p_dbg_gnt),    32'd0);
        check_val("rst_cpu_rvalid", 32'(p_cpu_rvalid), 32'd0);
        check_val("rst_dbg_rvalid", 32'(p_dbg_rvalid), 32'd0);
        check_val("rst_cpu_rdata",  32'(p_cpu_rdata),  32'd0);
        check_val("rst_dbg_rdata",  32'(p_dbg_rdata),  32'd0);
        check_val("rst_mem_we",     32'(p_mem_we),     32'd0);
        check_val("rst_mem_addr",   32'(p_mem_addr),   32'd0);
        check_val("rst_mem_wdata",  32'(p_mem_wdata),  32'd0);
        check_val("rst_busy",       32'(p_busy),       32'd0);
        step();

        for (int a = 0; a < 4; a++) issue(1'b0, 1'b1, 1'b1, a[1:0], 8'($urandom_range(0, 255)), 1'b1);

        // Single CPU write, cycle-accurate
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 2'd2; cpu_wdata = 8'hA5;
        gnt_q.push_back(1'b0);
        ref_mem[2] = 8'hA5;
        @(negedge clk);
        check_val("w1_T_busy", 32'(p_busy),    32'd0);
        check_val("w1_T_gnt",  32'(p_cpu_gnt), 32'd0);
        @(negedge clk);
        check_val("w1_T1_gnt",   32'(p_cpu_gnt),   32'd1);
        check_val("w1_T1_we",    32'(p_mem_we),    32'd1);
        check_val("w1_T1_addr",  32'(p_mem_addr),  32'd2);
        check_val("w1_T1_wdata", 32'(p_mem_wdata), 32'hA5);
        check_val("w1_T1_busy",  32'(p_busy),      32'd1);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        check_val("w1_T2_busy",   32'(p_busy),       32'd0);
        check_val("w1_T2_we",     32'(p_mem_we),     32'd0);
        check_val("w1_T2_rvalid", 32'(p_cpu_rvalid), 32'd0);
        step();

        // Debug read of the freshly written word
        issue(1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 1'b1);
        @(negedge clk);
        check_val("dr_rvalid",     32'(p_dbg_rvalid), 32'd1);
        check_val("dr_rdata",      32'(p_dbg_rdata),  32'hA5);
        check_val("dr_cpu_rvalid", 32'(p_cpu_rvalid), 32'd0);
        check_val("dr_cpu_rdata",  32'(p_cpu_rdata),  32'd0);
        step();

        // CPU write then read on the same address, back to back
        t0 = cyc;
        issue(1'b0, 1'b0, 1'b1, 2'd1, 8'h3C, 1'b1);
        issue(1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 1'b1);
        @(negedge clk);
        check_val("wr_rd_rvalid",  32'(p_cpu_rvalid), 32'd1);
        check_val("wr_rd_rdata",   32'(p_cpu_rdata),  32'h3C);
        check_val("wr_rd_latency", 32'(cyc - t0),     32'd4);
        step();

        // Starvation guard: CPU always requesting, dbg wins every 5th arbitration
        for (int i = 0; i < 11; i++) gnt_q.push_back((i == 4) || (i == 9));
        fork
            begin repeat (9) issue(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0); end
            begin repeat (2) issue(1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 1'b0); end
        join
        repeat (2) @(negedge clk);
        step();

        // Async reset in the ACCESS cycle of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 2'd3;
        @(posedge clk);
        #2;
        reset_p = 1'b1;
        cpu_req = 1'b0;
        #1;
        check_val("ra_busy",     32'(p_busy),     32'd0);
        check_val("ra_mem_we",   32'(p_mem_we),   32'd0);
        check_val("ra_cpu_gnt",  32'(p_cpu_gnt),  32'd0);
        check_val("ra_mem_addr", 32'(p_mem_addr), 32'd0);
        repeat (2) step();
        reset_p = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("ra_no_rvalid", 32'(p_cpu_rvalid), 32'd0);
            check_val("ra_no_gnt",    32'(p_cpu_gnt),    32'd0);
        end
        check_val("ra_cpu_rdata", 32'(p_cpu_rdata), 32'd0);
        step();

        issue(1'b0, 1'b1, 1'b1, 2'd0, 8'h5A, 1'b1);
        issue(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);

        for (int i = 0; i < 12; i++) begin
            issue(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b1);
        end
        repeat (3) @(negedge clk);
        step();

        // Round-robin instance: both ports keep requesting, grants alternate every 2 cycles
        reset_p = 1'b1;
        reset_r = 1'b0;
        step();
        for (int i = 0; i < 6; i++) rr_q.push_back(i[0]);
        fork
            begin for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, 1'b1, 2'(i), 8'(8'h10 + i), 1'b0); end
            begin for (int i = 0; i < 3; i++) issue(1'b1, 1'b1, 1'b1, 2'(i), 8'(8'h20 + i), 1'b0); end
        join
        repeat (3) @(negedge clk);

        check_val("gnt_q_empty",    32'(gnt_q.size()),    32'd0);
        check_val("rr_q_empty",     32'(rr_q.size()),     32'd0);
        check_val("cpu_rd_q_empty", 32'(cpu_rd_q.size()), 32'd0);
        check_val("dbg_rd_q_empty", 32'(dbg_rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
